// File: rtl/ibpl_cond_pkg.sv
// Shared constants and types for the interbackplane input conditioner.
// Build option: IBPL_COND_EDGE_CNT_EN adds the per-channel rising-edge counter constants.
package ibpl_cond_pkg;

    localparam int unsigned CHANNELS_MAX    = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILTER_W_DEF    = 4;
    localparam int unsigned STRETCH_DEF     = 6250000;
    localparam int unsigned STRETCH_W_DEF   = 23;
`ifdef IBPL_COND_EDGE_CNT_EN
    localparam int unsigned EDGE_CNT_W      = 16;
`endif

    typedef logic [CHANNELS_MAX-1:0] ch_vec_t;

endpackage

// File: rtl/ibpl_input_conditioner_if.sv
// Conditioner bus: raw pins/enables/filter length in, clean levels, edges and activity out.
// Build option: IBPL_COND_EDGE_CNT_EN adds cnt_clr and edge_cnt.
interface ibpl_input_conditioner_if
    import ibpl_cond_pkg::*;
#(
    parameter int unsigned FILTER_W = FILTER_W_DEF
);
    ch_vec_t               internal_in;
    ch_vec_t               input_enable;
    logic [FILTER_W-1:0]   filter_len;
    ch_vec_t               cond_out;
    ch_vec_t               rise_pulse;
    ch_vec_t               fall_pulse;
    ch_vec_t               input_act;
`ifdef IBPL_COND_EDGE_CNT_EN
    ch_vec_t                              cnt_clr;
    logic [CHANNELS_MAX*EDGE_CNT_W-1:0]   edge_cnt;

    modport master (
        output internal_in, input_enable, filter_len, cnt_clr,
        input  cond_out, rise_pulse, fall_pulse, input_act, edge_cnt
    );
    modport slave (
        input  internal_in, input_enable, filter_len, cnt_clr,
        output cond_out, rise_pulse, fall_pulse, input_act, edge_cnt
    );
`else
    modport master (
        output internal_in, input_enable, filter_len,
        input  cond_out, rise_pulse, fall_pulse, input_act
    );
    modport slave (
        input  internal_in, input_enable, filter_len,
        output cond_out, rise_pulse, fall_pulse, input_act
    );
`endif
endinterface

// File: rtl/ibpl_cond_channel.sv
// One conditioner channel: synchroniser, glitch filter, enable gate, edge detect, activity stretcher.
// Build option: IBPL_COND_EDGE_CNT_EN adds a saturating rising-edge counter.
module ibpl_cond_channel
    import ibpl_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_W       = FILTER_W_DEF,
    parameter int unsigned STRETCH_CYCLES = STRETCH_DEF,
    parameter int unsigned STRETCH_W      = STRETCH_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pin_i,
    input  logic                en_i,
    input  logic [FILTER_W-1:0] filter_len_i,
`ifdef IBPL_COND_EDGE_CNT_EN
    input  logic                   cnt_clr_i,
    output logic [EDGE_CNT_W-1:0]  edge_cnt_o,
`endif
    output logic                cond_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                act_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_W-1:0]    filt_q, filt_d;
    logic [STRETCH_W-1:0]   str_q, str_d;
    logic                   cond_q, cond_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   act_q, act_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Disable forces everything quiet; otherwise filter toggles once the difference persists.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        filt_d = filt_q;
        cond_d = cond_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        str_d  = str_q;
        act_d  = (str_q != '0);
        if (!en_i) begin
            filt_d = '0;
            cond_d = 1'b0;
            str_d  = '0;
        end else begin
            if (s == cond_q) begin
                filt_d = '0;
            end else if (filt_q >= filter_len_i) begin
                filt_d = '0;
                cond_d = ~cond_q;
                rise_d = ~cond_q;
                fall_d = cond_q;
            end else if (filt_q != '1) begin
                filt_d = filt_q + FILTER_W'(1);
            end
            if (rise_d || fall_d) begin
                str_d = STRETCH_W'(STRETCH_CYCLES);
            end else if (str_q != '0) begin
                str_d = str_q - STRETCH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            filt_q <= '0;
            cond_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            str_q  <= '0;
            act_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cond_q <= cond_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            str_q  <= str_d;
            act_q  <= act_d;
        end
    end

    assign cond_o = cond_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign act_o  = act_q;

`ifdef IBPL_COND_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] ecnt_q, ecnt_d;

    // Clear wins over a coincident rising edge; count sticks at all-ones.
    always_comb begin
        ecnt_d = ecnt_q;
        if (cnt_clr_i) begin
            ecnt_d = '0;
        end else if (rise_q && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + EDGE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign edge_cnt_o = ecnt_q;
`endif

endmodule

// File: rtl/ibpl_input_conditioner.sv
// Top: CHANNELS conditioner channels, outputs zero-padded to the full 8-bit bus.
// Build option: IBPL_COND_EDGE_CNT_EN enables per-channel rising-edge counters.
module ibpl_input_conditioner
    import ibpl_cond_pkg::*;
#(
    parameter int unsigned CHANNELS       = CHANNELS_MAX,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_W       = FILTER_W_DEF,
    parameter int unsigned STRETCH_CYCLES = STRETCH_DEF,
    parameter int unsigned STRETCH_W      = STRETCH_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    ibpl_input_conditioner_if.slave   bus
);

    logic cond_w [CHANNELS_MAX];
    logic rise_w [CHANNELS_MAX];
    logic fall_w [CHANNELS_MAX];
    logic act_w  [CHANNELS_MAX];
`ifdef IBPL_COND_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] ecnt_w [CHANNELS_MAX];
`endif

    for (genvar g = 0; g < CHANNELS_MAX; g++) begin : g_ch
        if (g < CHANNELS) begin : g_on
            ibpl_cond_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .FILTER_W       (FILTER_W),
                .STRETCH_CYCLES (STRETCH_CYCLES),
                .STRETCH_W      (STRETCH_W)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .pin_i        (bus.internal_in[g]),
                .en_i         (bus.input_enable[g]),
                .filter_len_i (bus.filter_len),
`ifdef IBPL_COND_EDGE_CNT_EN
                .cnt_clr_i    (bus.cnt_clr[g]),
                .edge_cnt_o   (ecnt_w[g]),
`endif
                .cond_o       (cond_w[g]),
                .rise_o       (rise_w[g]),
                .fall_o       (fall_w[g]),
                .act_o        (act_w[g])
            );
        end else begin : g_off
            assign cond_w[g] = 1'b0;
            assign rise_w[g] = 1'b0;
            assign fall_w[g] = 1'b0;
            assign act_w[g]  = 1'b0;
`ifdef IBPL_COND_EDGE_CNT_EN
            assign ecnt_w[g] = '0;
`endif
        end
    end

    // Pack per-channel results onto the bus.
    always_comb begin
        bus.cond_out   = '0;
        bus.rise_pulse = '0;
        bus.fall_pulse = '0;
        bus.input_act  = '0;
`ifdef IBPL_COND_EDGE_CNT_EN
        bus.edge_cnt   = '0;
`endif
        for (int i = 0; i < CHANNELS_MAX; i++) begin
            bus.cond_out[i]   = cond_w[i];
            bus.rise_pulse[i] = rise_w[i];
            bus.fall_pulse[i] = fall_w[i];
            bus.input_act[i]  = act_w[i];
`ifdef IBPL_COND_EDGE_CNT_EN
            bus.edge_cnt[EDGE_CNT_W*i +: EDGE_CNT_W] = ecnt_w[i];
`endif
        end
    end

endmodule

// File: tb/tb_ibpl_input_conditioner.sv
// Directed bench for ibpl_input_conditioner with STRETCH_CYCLES=10.
// Build option: IBPL_COND_EDGE_CNT_EN adds the edge-counter scenario.
module tb_ibpl_input_conditioner;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ibpl_input_conditioner_if #(.FILTER_W(4)) bus ();

    ibpl_input_conditioner #(
        .CHANNELS       (8),
        .SYNC_STAGES    (2),
        .FILTER_W       (4),
        .STRETCH_CYCLES (10),
        .STRETCH_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.cond_out, bus.rise_pulse, bus.fall_pulse, bus.input_act} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {bus.cond_out, bus.rise_pulse, bus.fall_pulse, bus.input_act});
        end
`ifdef IBPL_COND_EDGE_CNT_EN
        checks++;
        if (bus.edge_cnt !== 128'h0) begin
            errors++;
            $display("FAIL reset_edge_cnt: got %h required 0", bus.edge_cnt);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    // Pin0 rise: 6-cycle latency, single pulse, 10-cycle activity; then the fall.
    task automatic test_rise_fall();
        bus.internal_in[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (bus.cond_out[0] !== (k == 6)) begin
                errors++;
                $display("FAIL rise_latency k=%0d: got %b required %b", k, bus.cond_out[0], k == 6);
            end
        end
        checks++;
        if (bus.rise_pulse[0] !== 1'b1 || bus.fall_pulse[0] !== 1'b0 || bus.input_act[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_pulse: got rise=%b fall=%b act=%b required 1 0 0",
                     bus.rise_pulse[0], bus.fall_pulse[0], bus.input_act[0]);
        end
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++;
            if (bus.input_act[0] !== (k <= 10) || bus.rise_pulse[0] !== 1'b0) begin
                errors++;
                $display("FAIL act_stretch k=%0d: got act=%b rise=%b required act=%b rise=0",
                         k, bus.input_act[0], bus.rise_pulse[0], k <= 10);
            end
        end
        bus.internal_in[0] = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.cond_out[0] !== 1'b1 || bus.fall_pulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL fall_early: got cond=%b fall=%b required 1 0", bus.cond_out[0], bus.fall_pulse[0]);
        end
        tick();
        checks++;
        if (bus.cond_out[0] !== 1'b0 || bus.fall_pulse[0] !== 1'b1 || bus.rise_pulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL fall_pulse: got cond=%b fall=%b rise=%b required 0 1 0",
                     bus.cond_out[0], bus.fall_pulse[0], bus.rise_pulse[0]);
        end
        repeat (12) tick();
    endtask

    // A 3-cycle glitch with filter_len=3 must never pass.
    task automatic test_glitch();
        logic [2:0] seen;
        seen = 3'b000;
        bus.internal_in[1] = 1'b1;
        repeat (3) tick();
        seen |= {bus.cond_out[1], bus.rise_pulse[1], bus.input_act[1]};
        bus.internal_in[1] = 1'b0;
        repeat (10) begin
            tick();
            seen |= {bus.cond_out[1], bus.rise_pulse[1], bus.input_act[1]};
        end
        checks++;
        if (seen !== 3'b000) begin
            errors++;
            $display("FAIL glitch_blocked: got cond/rise/act=%b required 000", seen);
        end
    endtask

    // Disabled channel stays silent, then rises filter_len+1 cycles after enable.
    task automatic test_enable();
        logic [3:0] seen;
        seen = 4'h0;
        bus.input_enable[2] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            bus.internal_in[2] = ((k / 20) % 2 == 0);
            tick();
            seen |= {bus.cond_out[2], bus.rise_pulse[2], bus.fall_pulse[2], bus.input_act[2]};
        end
        checks++;
        if (seen !== 4'h0) begin
            errors++;
            $display("FAIL disabled_quiet: got cond/rise/fall/act=%b required 0000", seen);
        end
        bus.input_enable[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.cond_out[2] !== (k == 4) || bus.rise_pulse[2] !== (k == 4)) begin
                errors++;
                $display("FAIL enable_rise k=%0d: got cond=%b rise=%b required %b",
                         k, bus.cond_out[2], bus.rise_pulse[2], k == 4);
            end
        end
        repeat (12) tick();
    endtask

    // Dropping enable while high clears cond_out silently.
    task automatic test_enable_drop();
        bus.internal_in[3] = 1'b1;
        repeat (6) tick();
        checks++;
        if (bus.cond_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL drop_setup: got cond=%b required 1", bus.cond_out[3]);
        end
        repeat (12) tick();
        bus.input_enable[3] = 1'b0;
        tick();
        checks++;
        if (bus.cond_out[3] !== 1'b0 || bus.fall_pulse[3] !== 1'b0 || bus.input_act[3] !== 1'b0) begin
            errors++;
            $display("FAIL drop_silent: got cond=%b fall=%b act=%b required 0 0 0",
                     bus.cond_out[3], bus.fall_pulse[3], bus.input_act[3]);
        end
        bus.internal_in[3] = 1'b0;
        repeat (4) tick();
        bus.input_enable[3] = 1'b1;
        repeat (6) tick();
        checks++;
        if ({bus.cond_out[3], bus.rise_pulse[3], bus.fall_pulse[3], bus.input_act[3]} !== 4'h0) begin
            errors++;
            $display("FAIL drop_reenable: got %b required 0000",
                     {bus.cond_out[3], bus.rise_pulse[3], bus.fall_pulse[3], bus.input_act[3]});
        end
    endtask

    // Edges every 4 cycles keep activity on; it ends 10 cycles after the last edge.
    task automatic test_retrigger();
        int bad;
        bad = 0;
        bus.filter_len = 4'd0;
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 0) bus.internal_in[4] = ~bus.internal_in[4];
            tick();
            if (k >= 3 && bus.input_act[4] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL retrigger_hold: got %0d low cycles required 0", bad);
        end
        checks++;
        if (bus.rise_pulse[4] !== 1'b0 || bus.cond_out[4] !== 1'b0) begin
            errors++;
            $display("FAIL retrigger_last: got rise=%b cond=%b required 0 0", bus.rise_pulse[4], bus.cond_out[4]);
        end
        for (int k = 25; k <= 34; k++) begin
            tick();
            checks++;
            if (bus.input_act[4] !== (k <= 33)) begin
                errors++;
                $display("FAIL retrigger_tail edge=%0d: got %b required %b", k, bus.input_act[4], k <= 33);
            end
        end
        bus.filter_len = 4'd3;
    endtask

`ifdef IBPL_COND_EDGE_CNT_EN
    task automatic test_edge_cnt();
        logic found;
        logic [15:0] cnt;
        bus.filter_len = 4'd0;
        repeat (5) begin
            bus.internal_in[5] = 1'b1;
            repeat (4) tick();
            bus.internal_in[5] = 1'b0;
            repeat (4) tick();
        end
        repeat (4) tick();
        cnt = bus.edge_cnt[95:80];
        checks++;
        if (cnt !== 16'd5) begin
            errors++;
            $display("FAIL edge_cnt_five: got %0d required 5", cnt);
        end
        bus.internal_in[5] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            found = bus.rise_pulse[5];
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL edge_cnt_wait: got no rise_pulse required one within 8 cycles");
        end
        bus.cnt_clr[5] = 1'b1;
        tick();
        bus.cnt_clr[5] = 1'b0;
        cnt = bus.edge_cnt[95:80];
        checks++;
        if (cnt !== 16'd0) begin
            errors++;
            $display("FAIL edge_cnt_clr: got %0d required 0", cnt);
        end
        repeat (2) tick();
        cnt = bus.edge_cnt[95:80];
        checks++;
        if (cnt !== 16'd0) begin
            errors++;
            $display("FAIL edge_cnt_after_clr: got %0d required 0", cnt);
        end
        bus.internal_in[5] = 1'b0;
        repeat (15) tick();
        bus.filter_len = 4'd3;
    endtask
`endif

    // Reset mid-count discards the pending filter progress.
    task automatic test_reset_mid();
        bus.internal_in[6] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.cond_out, bus.rise_pulse, bus.fall_pulse, bus.input_act} !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h required 0",
                     {bus.cond_out, bus.rise_pulse, bus.fall_pulse, bus.input_act});
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (bus.cond_out[6] !== (k == 6)) begin
                errors++;
                $display("FAIL reset_restart k=%0d: got %b required %b", k, bus.cond_out[6], k == 6);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.internal_in  = 8'h00;
        bus.input_enable = 8'hFF;
        bus.filter_len   = 4'd3;
`ifdef IBPL_COND_EDGE_CNT_EN
        bus.cnt_clr      = 8'h00;
`endif
        test_reset();
        test_rise_fall();
        test_glitch();
        test_enable();
        test_enable_drop();
        test_retrigger();
`ifdef IBPL_COND_EDGE_CNT_EN
        test_edge_cnt();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibpl_input_conditioner.md
Name: ibpl_input_conditioner

Overview:
- Per-channel conditioning stage directly downstream of interbackplane input cardlets; consumes raw `internal_in` bits.
- Synchronises each bit, glitch-filters it, gates it with `input_enable`, and detects edges.
- Produces the `input_act` activity vector that input cardlets drive onto their LED bank, plus clean levels and edge pulses for the blackbox core.

Parameters:
- CHANNELS, 8, number of input channels (1..8).
- SYNC_STAGES, 2, synchroniser flip-flop depth (>=2).
- FILTER_W, 4, width of the runtime filter-length field and of each filter counter.
- STRETCH_CYCLES, 6250000, activity LED on-time in clk cycles (50 ms at 125 MHz); >=1.
- STRETCH_W, 23, stretch counter width; must hold STRETCH_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- internal_in  in  CHANNELS  raw asynchronous cardlet inputs.
- input_enable  in  CHANNELS  per-channel enable, synchronous to clk.
- filter_len  in  FILTER_W  required stable cycles minus one; synchronous, quasi-static.
- cond_out  out  CHANNELS  filtered, enabled input levels.
- rise_pulse  out  CHANNELS  one-cycle pulse on a cond_out 0->1 transition.
- fall_pulse  out  CHANNELS  one-cycle pulse on a cond_out 1->0 transition.
- input_act  out  CHANNELS  stretched activity indication.

Behaviour:
- Clock and reset: single clk domain; rst is synchronous and active-high.
- Reset values: all synchroniser flops, filter counters, cond_out, rise_pulse, fall_pulse, stretch counters and input_act are 0.
- Synchroniser: SYNC_STAGES flops per bit. The final stage output is `s[i]`.
- Filter, per channel:
  - When `s[i] == cond_out[i]`, the counter clears.
  - Otherwise the counter increments. When it equals filter_len, cond_out toggles on the next edge and the counter clears.
  - filter_len=0 therefore means 1 cycle of difference is required.
  - Latency from a pin change to cond_out = SYNC_STAGES + filter_len + 1 cycles.
  - A glitch shorter than filter_len+1 cycles never reaches cond_out.
  - The counter saturates at all-ones and never wraps.
  - If filter_len is lowered below the current count, the toggle occurs on the next cycle that still differs.
- Enable:
  - While input_enable[i]=0: cond_out[i], the filter counter and the stretch counter are held at 0, and no pulses are issued.
  - When input_enable falls while cond_out=1: cond_out goes to 0 silently, with no fall_pulse and no activity.
  - After enable rises, the filter restarts from cond_out=0.
- Edges: rise_pulse and fall_pulse are registered and asserted in the same cycle cond_out changes. They are mutually exclusive per channel.
- Activity stretcher:
  - Any edge loads the counter with STRETCH_CYCLES.
  - Otherwise the counter decrements while nonzero.
  - input_act[i] = (counter != 0), registered.
  - input_act is high exactly STRETCH_CYCLES cycles after an isolated edge, starting the cycle after the pulse.
  - A retrigger while active reloads the counter and does not accumulate.
- Simultaneous events:
  - enable=0 has priority over the filter toggle and over the stretcher load.
  - rst has priority over everything.
- Reset mid-operation: all state returns to its reset values on the next clk edge. A pending filter count is discarded.
- Unused bits: when CHANNELS<8, a wrapper zero-pads the outputs.

Optional Feature:
- Macro: `IBPL_COND_EDGE_CNT_EN`.
- With the macro:
  - Adds `cnt_clr` input (CHANNELS wide).
  - Adds `edge_cnt` output, CHANNELS×16 bits packed, channel i at [16i+15:16i].
  - Per-channel rising-edge counter increments on rise_pulse and saturates at 16'hFFFF.
  - `cnt_clr[i]` zeroes counter i, with priority over increment.
  - Counters reset to 0.
- Without the macro: these ports and counters do not exist.

Decomposition:
- Shared package `ibpl_cond_pkg`, holding:
  - default constants: CHANNELS_MAX=8, SYNC_STAGES_DEF=2, FILTER_W_DEF=4, STRETCH_DEF;
  - typedef `ch_vec_t` (logic [7:0]).
- Sub-module `ibpl_cond_channel`: one channel's synchroniser, filter, edge detect and stretcher. The top level instantiates it CHANNELS times with a generate loop.

Test Plan:
- Reset, STRETCH_CYCLES=10, filter_len=3, enable=8'hFF, pin0 held 1 → cond_out[0] rises 2+4=6 cycles after the pin change; rise_pulse[0] for 1 cycle; input_act[0] high for exactly 10 cycles.
- filter_len=3, pin1 high for 3 cycles then low → cond_out, pulses and input_act all stay 0.
- enable[2]=0, pin2 toggling every 20 cycles → outputs for channel 2 stay 0. Then enable[2]=1 with pin2=1 → rise after filter_len+1 cycles.
- cond_out[3]=1, drop enable[3] → cond_out[3]=0 next cycle with no fall_pulse; input_act unaffected.
- Edges on channel 4 every 4 cycles with STRETCH_CYCLES=10 → input_act[4] continuously high; low exactly 10 cycles after the final edge.
- `IBPL_COND_EDGE_CNT_EN`: 5 rising edges on channel 5 → edge_cnt[95:80]=5. cnt_clr[5] in the same cycle as a rise_pulse → 0.
